boot_loader_ctrl: RTL and testbench

Boot-time controller that sits between the multicycle RISC-V core and its single unified memory port. Out of reset it holds the core in reset and owns the memory port. It receives a program image as a byte stream (valid/ready), packs the bytes into little-endian 32-bit words and writes them to consecutive memory words. It then releases the core and hands the memory port over to it for the rest of operation.

---
 rtl/boot_loader_pkg.sv | 25 ++
 rtl/boot_loader_if.sv | 23 ++
 rtl/byte_packer.sv | 45 ++++
 rtl/boot_loader_ctrl.sv | 155 +++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader.
// BOOT_LOADER_CHECKSUM_EN adds the CHK state to the state encoding.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN0  = 3'd0,
        ST_LEN1  = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
`ifdef BOOT_LOADER_CHECKSUM_EN
        ST_CHK   = 3'd4,
`endif
        ST_RUN   = 3'd5,
        ST_ERROR = 3'd6
    } boot_state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    // Byte address of word idx; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream, core-side and memory-side bus of the boot loader.
// master = loader view, slave = surrounding system view.
interface boot_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] cpu_addr;
    logic        cpu_we;
    logic [31:0] cpu_wdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;

    modport master (
        input  in_data, in_valid, cpu_addr, cpu_we, cpu_wdata,
        output in_ready, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        output in_data, in_valid, cpu_addr, cpu_we, cpu_wdata,
        input  in_ready, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/byte_packer.sv
// Packs accepted bytes into a little-endian 32-bit word; word_done marks
// the strobe that delivers the last lane.
module byte_packer
    import boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        strobe,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_done
);

    localparam logic [1:0] BC_LAST = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  bc_r;
    logic [31:0] word_r;

    // Lane counter and word assembly register.
    always_ff @(posedge clk) begin
        if (reset) begin
            bc_r   <= 2'd0;
            word_r <= 32'd0;
        end else if (clear) begin
            bc_r   <= 2'd0;
        end else if (strobe) begin
            word_r[{bc_r, 3'b000} +: 8] <= byte_in;
            bc_r                        <= bc_r + 2'd1;
        end
    end

    // Completion pulse on the strobe that fills the top lane.
    always_comb begin
        word_done = 1'b0;
        if (strobe && !clear && (bc_r == BC_LAST)) begin
            word_done = 1'b1;
        end else begin
            word_done = 1'b0;
        end
    end

    assign word = word_r;

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot loader: streams an image into memory, then releases the core and
// hands it the memory port. Optional checksum via BOOT_LOADER_CHECKSUM_EN.
module boot_loader_ctrl
    import boot_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    boot_loader_if.master     bus,
    output logic              core_reset,
    output logic              loaded,
    output logic              error
);

    localparam logic [16:0] MAX_WORDS_W = 17'(MAX_WORDS);
`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam boot_state_t DONE_STATE = ST_CHK;
`else
    localparam boot_state_t DONE_STATE = ST_RUN;
`endif

    boot_state_t state_r, next_state_s;
    logic [15:0] n_r;
    logic [15:0] idx_r;
    logic [15:0] len_s;
    logic [31:0] word_s;
    logic        word_done_s;
    logic        accept_s;
    logic        ready_s;
    logic        we_s;
    logic        core_rst_s;
    logic        loaded_s;
    logic        error_s;
    logic [31:0] addr_s;
    logic [31:0] wdata_s;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]  acc_r;
    logic [7:0]  sum_s;
    assign sum_s = acc_r + bus.in_data;
`endif

    assign accept_s = bus.in_valid && bus.in_ready;
    assign len_s    = {bus.in_data, n_r[7:0]};

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .byte_in   (bus.in_data),
        .strobe    (accept_s && (state_r == ST_DATA)),
        .clear     ((state_r != ST_DATA) && (state_r != ST_WRITE)),
        .word      (word_s),
        .word_done (word_done_s)
    );

    // State, length, word index and checksum accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_LEN0;
            n_r     <= 16'd0;
            idx_r   <= 16'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            acc_r   <= 8'd0;
`endif
        end else begin
            state_r <= next_state_s;
            if (accept_s && (state_r == ST_LEN0)) begin
                n_r[7:0] <= bus.in_data;
            end else if (accept_s && (state_r == ST_LEN1)) begin
                n_r[15:8] <= bus.in_data;
            end
            if (state_r == ST_WRITE) begin
                idx_r <= idx_r + 16'd1;
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            if (accept_s) begin
                acc_r <= sum_s;
            end
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_LEN0: begin
                if (accept_s) next_state_s = ST_LEN1;
                else          next_state_s = ST_LEN0;
            end
            ST_LEN1: begin
                if (!accept_s)                        next_state_s = ST_LEN1;
                else if ({1'b0, len_s} > MAX_WORDS_W) next_state_s = ST_ERROR;
                else if (len_s == 16'd0)              next_state_s = DONE_STATE;
                else                                  next_state_s = ST_DATA;
            end
            ST_DATA: begin
                if (word_done_s) next_state_s = ST_WRITE;
                else             next_state_s = ST_DATA;
            end
            ST_WRITE: begin
                if (({1'b0, idx_r} + 17'd1) == {1'b0, n_r}) next_state_s = DONE_STATE;
                else                                        next_state_s = ST_DATA;
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (!accept_s)           next_state_s = ST_CHK;
                else if (sum_s == 8'h00) next_state_s = ST_RUN;
                else                     next_state_s = ST_ERROR;
            end
`endif
            ST_RUN:   next_state_s = ST_RUN;
            ST_ERROR: next_state_s = ST_ERROR;
            default:  next_state_s = ST_ERROR;
        endcase
    end

    // Output decode; the port belongs to the core only in RUN.
    always_comb begin
        ready_s    = 1'b0;
        we_s       = 1'b0;
        core_rst_s = 1'b1;
        loaded_s   = 1'b0;
        error_s    = 1'b0;
        addr_s     = word_addr(BASE_ADDR, idx_r);
        wdata_s    = word_s;
        case (state_r)
            ST_LEN0, ST_LEN1, ST_DATA: ready_s = 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
            ST_CHK:   ready_s = 1'b1;
`endif
            ST_WRITE: we_s = 1'b1;
            ST_RUN: begin
                core_rst_s = 1'b0;
                loaded_s   = 1'b1;
                addr_s     = bus.cpu_addr;
                we_s       = bus.cpu_we;
                wdata_s    = bus.cpu_wdata;
            end
            ST_ERROR: error_s = 1'b1;
            default:  error_s = 1'b1;
        endcase
    end

    // Reset overrides the decode so the core is held from the first cycle.
    assign bus.in_ready  = ready_s && !reset;
    assign bus.mem_we    = we_s && !reset;
    assign bus.mem_addr  = addr_s;
    assign bus.mem_wdata = wdata_s;
    assign core_reset    = core_rst_s || reset;
    assign loaded        = loaded_s && !reset;
    assign error         = error_s && !reset;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl (MAX_WORDS=4, BASE_ADDR=0x1000).
// Honours BOOT_LOADER_CHECKSUM_EN for the checksum byte and CHK timing.
module tb_boot_loader_ctrl;

    localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic core_reset, loaded, error;
    int   checks = 0, failures = 0;
    int   cyc = 0, we_cnt = 0, viol = 0;
    int   c0, we0;
    logic [31:0] mem [0:15];

    always #5 clk = ~clk;

    boot_loader_if bif ();

    boot_loader_ctrl #(.BASE_ADDR(BASE), .MAX_WORDS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bif.master),
        .core_reset (core_reset),
        .loaded     (loaded),
        .error      (error)
    );

    // Memory model, write counter and in_ready-during-WRITE monitor.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bif.mem_we === 1'b1) begin
            we_cnt <= we_cnt + 1;
            if (bif.mem_addr[31:6] == BASE[31:6]) mem[bif.mem_addr[5:2]] <= bif.mem_wdata;
        end
        if (bif.mem_we === 1'b1 && core_reset === 1'b1 && bif.in_ready !== 1'b0) viol <= viol + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t = 0;
        for (int i = 0; i < gap; i++) begin
            bif.in_valid = 1'b0;
            tick();
        end
        bif.in_data  = b;
        bif.in_valid = 1'b1;
        while (bif.in_ready !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        checks++;
        assert (t < 20) else begin
            failures++;
            $error("FAIL send_timeout observed=%0d expected=<20 cycles", t);
        end
        tick();
        bif.in_valid = 1'b0;
    endtask

    task automatic send_img2(input int maxgap, input logic [7:0] ck);
        logic [7:0] img [10] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 10; i++) send(img[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        if (CK == 1) send(ck, 0);
    endtask

    task automatic wait_loaded();
        int t = 0;
        while (loaded !== 1'b1 && t < 40) begin
            tick();
            t++;
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bif.in_valid = 1'b0;
        tick();
        chk1("rst_core_reset", core_reset, 1'b1);
        chk1("rst_in_ready", bif.in_ready, 1'b0);
        reset = 1'b0;
        c0    = cyc;
        we0   = we_cnt;
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        bif.in_valid  = 1'b0;
        bif.in_data   = 8'h00;
        bif.cpu_addr  = 32'hFFFF_FFF0;
        bif.cpu_we    = 1'b1;
        bif.cpu_wdata = 32'hA5A5_A5A5;
        tick();
        tick();
        chk1("reset_in_ready", bif.in_ready, 1'b0);
        chk1("reset_core_reset", core_reset, 1'b1);
        chk1("reset_mem_we", bif.mem_we, 1'b0);
        chk1("reset_loaded", loaded, 1'b0);
        chk1("reset_error", error, 1'b0);
        reset = 1'b0;
        c0    = cyc;
        we0   = we_cnt;
        #1;
        chk1("first_cycle_in_ready", bif.in_ready, 1'b1);

        // Two-word image at full rate; cpu_we held high must be ignored.
        send_img2(0, 8'hB2);
        wait_loaded();
        chk1("two_loaded", loaded, 1'b1);
        chk32("two_cycles", 32'(cyc - c0), 32'(12 + CK));
        chk1("two_core_reset", core_reset, 1'b0);
        chk32("two_we_pulses", 32'(we_cnt - we0), 32'd2);
        chk32("two_word0", mem[0], 32'h1234_5678);
        chk32("two_word1", mem[1], 32'hDEAD_BEEF);
        chk32("two_run_addr", bif.mem_addr, 32'hFFFF_FFF0);
        bif.cpu_we = 1'b0;

        // Empty image.
        do_reset();
        send(8'h00, 0);
        send(8'h00, 0);
        if (CK == 1) send(8'h00, 0);
        chk1("n0_loaded", loaded, 1'b1);
        chk1("n0_core_reset", core_reset, 1'b0);
        chk32("n0_we_pulses", 32'(we_cnt - we0), 32'd0);

        // Oversize length.
        do_reset();
        bif.cpu_we = 1'b1;
        send(8'h05, 0);
        send(8'h00, 0);
        tick();
        chk1("over_error", error, 1'b1);
        chk1("over_in_ready", bif.in_ready, 1'b0);
        chk1("over_core_reset", core_reset, 1'b1);
        chk1("over_mem_we", bif.mem_we, 1'b0);
        tick();
        chk32("over_we_pulses", 32'(we_cnt - we0), 32'd0);
        bif.cpu_we = 1'b0;

        // Length exactly MAX_WORDS is accepted.
        do_reset();
        send(8'h04, 0);
        send(8'h00, 0);
        chk1("max_error", error, 1'b0);
        chk1("max_in_ready", bif.in_ready, 1'b1);

`ifdef BOOT_LOADER_CHECKSUM_EN
        // Wrong checksum byte.
        do_reset();
        send_img2(0, 8'hB3);
        tick();
        chk1("badck_error", error, 1'b1);
        chk1("badck_core_reset", core_reset, 1'b1);
        chk1("badck_loaded", loaded, 1'b0);
`endif

        // Reset after three data bytes, then a fresh one-word image.
        do_reset();
        send(8'h02, 0);
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'h02, 0);
        send(8'h03, 0);
        do_reset();
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'h44, 0);
        send(8'h33, 0);
        send(8'h22, 0);
        send(8'h11, 0);
        if (CK == 1) send(8'h55, 0);
        wait_loaded();
        chk1("mid_loaded", loaded, 1'b1);
        chk32("mid_word0", mem[0], 32'h1122_3344);
        chk32("mid_word1_kept", mem[1], 32'hDEAD_BEEF);
        chk32("mid_we_pulses", 32'(we_cnt - we0), 32'd1);
        bif.cpu_addr  = 32'h0000_2468;
        bif.cpu_we    = 1'b1;
        bif.cpu_wdata = 32'hCAFE_F00D;
        #1;
        chk32("pass_addr", bif.mem_addr, 32'h0000_2468);
        chk1("pass_we", bif.mem_we, 1'b1);
        chk32("pass_wdata", bif.mem_wdata, 32'hCAFE_F00D);
        bif.cpu_we = 1'b0;
        tick();

        // Same two-word image with random in_valid gaps.
        do_reset();
        send_img2(3, 8'hB2);
        wait_loaded();
        chk1("gap_loaded", loaded, 1'b1);
        chk32("gap_word0", mem[0], 32'h1234_5678);
        chk32("gap_word1", mem[1], 32'hDEAD_BEEF);
        chk32("gap_we_pulses", 32'(we_cnt - we0), 32'd2);
        chk32("write_cycle_ready_low", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
